// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: shares one fixed-latency memory port between the
// CPU MEM stage (port C) and a DMA/peripheral master (port D). One access is
// in flight at a time; each access walks IDLE -> ISSUE -> WAIT -> DONE.
//
// Handshake: a requester raises *_req together with we/addr/wdata/be and holds
// them until its one-cycle *_done pulse. Fields are latched at grant, so a
// request that drops mid-access still completes and still pulses done.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LAT     = 1,
  parameter int CPU_PRIORITY = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [DATA_W/8-1:0] cpu_be,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_done,
  output logic                cpu_stall,
  input  logic                dma_req,
  input  logic                dma_we,
  input  logic [ADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]   dma_wdata,
  input  logic [DATA_W/8-1:0] dma_be,
  output logic [DATA_W-1:0]   dma_rdata,
  output logic                dma_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = 4;
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              grant;

  // Tie-break: fixed CPU priority, or alternate away from the last winner.
  always_comb begin
    grant = OWN_C;
    if (cpu_req && dma_req) begin
      grant = (CPU_PRIORITY != 0) ? OWN_C : ~last_grant_q;
    end else if (dma_req) begin
      grant = OWN_D;
    end
  end

  // Next-state logic: arbitration, access sequencing and read-data capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          owner_d      = grant;
          last_grant_d = grant;
          mem_we_d     = (grant == OWN_D) ? dma_we    : cpu_we;
          mem_addr_d   = (grant == OWN_D) ? dma_addr  : cpu_addr;
          mem_wdata_d  = (grant == OWN_D) ? dma_wdata : cpu_wdata;
          mem_be_d     = (grant == OWN_D) ? dma_be    : cpu_be;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(READ_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // Writes leave the read-data registers untouched.
          if (!mem_we_q) begin
            if (owner_q == OWN_D) dma_rdata_d = mem_rdata;
            else                  cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_C;
      last_grant_q <= OWN_D;
      cnt_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_done  = (state_q == S_DONE) && (owner_q == OWN_C);
  assign dma_done  = (state_q == S_DONE) && (owner_q == OWN_D);
  // Stall holds the pipeline whenever the CPU waits, including behind DMA.
  assign cpu_stall = cpu_req & ~cpu_done;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Instance a: READ_LAT=1, round-robin.
// Instance b: READ_LAT=3, CPU priority. Each instance has its own memory model
// whose read data is a function of the address and is only valid exactly
// READ_LAT cycles after mem_req (a marker value otherwise).
module tb_dmem_arbiter;

  logic clk;
  int   compared   = 0;
  int   mismatched = 0;

  // instance a signals
  logic        a_rst_n;
  logic        a_cpu_req, a_cpu_we, a_cpu_done, a_cpu_stall;
  logic [31:0] a_cpu_addr, a_cpu_wdata, a_cpu_rdata;
  logic [3:0]  a_cpu_be;
  logic        a_dma_req, a_dma_we, a_dma_done;
  logic [31:0] a_dma_addr, a_dma_wdata, a_dma_rdata;
  logic [3:0]  a_dma_be;
  logic        a_mem_req, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;
  logic [1:0]  a_dbg_state;

  // instance b signals
  logic        b_rst_n;
  logic        b_cpu_req, b_cpu_we, b_cpu_done, b_cpu_stall;
  logic [31:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
  logic [3:0]  b_cpu_be;
  logic        b_dma_req, b_dma_we, b_dma_done;
  logic [31:0] b_dma_addr, b_dma_wdata, b_dma_rdata;
  logic [3:0]  b_dma_be;
  logic        b_mem_req, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_dbg_state;
  logic [31:0] b_pipe [3];

  // Scoreboard entries: {is_read, expected rdata}
  logic [32:0] exp_a_c_q[$];
  logic [32:0] exp_a_d_q[$];
  logic [32:0] exp_b_c_q[$];
  logic [32:0] exp_b_d_q[$];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1), .CPU_PRIORITY(0)) u_a (
    .clk(clk), .rst_n(a_rst_n),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_be(a_cpu_be), .cpu_rdata(a_cpu_rdata), .cpu_done(a_cpu_done), .cpu_stall(a_cpu_stall),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_be(a_dma_be), .dma_rdata(a_dma_rdata), .dma_done(a_dma_done),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_be(a_mem_be), .mem_rdata(a_mem_rdata), .dbg_state(a_dbg_state)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3), .CPU_PRIORITY(1)) u_b (
    .clk(clk), .rst_n(b_rst_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_be(b_cpu_be), .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_be(b_dma_be), .dma_rdata(b_dma_rdata), .dma_done(b_dma_done),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_be(b_mem_be), .mem_rdata(b_mem_rdata), .dbg_state(b_dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  function automatic logic [31:0] mdata(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  always @(posedge clk) a_mem_rdata <= a_mem_req ? mdata(a_mem_addr) : 32'hBAD0_0000;

  always @(posedge clk) begin
    b_pipe[0] <= b_mem_req ? mdata(b_mem_addr) : 32'hBAD0_0000;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sb_push(input int dut, input bit port, input logic we, input logic [31:0] addr);
    logic [32:0] e;
    e = we ? 33'h0 : {1'b1, mdata(addr)};
    if (dut == 0) begin
      if (port) exp_a_d_q.push_back(e); else exp_a_c_q.push_back(e);
    end else begin
      if (port) exp_b_d_q.push_back(e); else exp_b_c_q.push_back(e);
    end
  endtask

  // port 0 = CPU, 1 = DMA
  task automatic drive(input int dut, input bit port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    sb_push(dut, port, we, addr);
    if (dut == 0 && !port) begin a_cpu_req = 1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata; a_cpu_be = be; end
    if (dut == 0 &&  port) begin a_dma_req = 1; a_dma_we = we; a_dma_addr = addr; a_dma_wdata = wdata; a_dma_be = be; end
    if (dut == 1 && !port) begin b_cpu_req = 1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata; b_cpu_be = be; end
    if (dut == 1 &&  port) begin b_dma_req = 1; b_dma_we = we; b_dma_addr = addr; b_dma_wdata = wdata; b_dma_be = be; end
  endtask

  task automatic reset_a();
    a_rst_n = 0; a_cpu_req = 0; a_dma_req = 0;
    tick(2);
    a_rst_n = 1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (a_cpu_done) begin
      if (exp_a_c_q.size() == 0) check("a_cpu_done_unexpected", {31'd0, a_cpu_done}, 32'd0);
      else begin e = exp_a_c_q.pop_front(); if (e[32]) check("a_cpu_rdata_sb", a_cpu_rdata, e[31:0]); end
    end
    if (a_dma_done) begin
      if (exp_a_d_q.size() == 0) check("a_dma_done_unexpected", {31'd0, a_dma_done}, 32'd0);
      else begin e = exp_a_d_q.pop_front(); if (e[32]) check("a_dma_rdata_sb", a_dma_rdata, e[31:0]); end
    end
    if (b_cpu_done) begin
      if (exp_b_c_q.size() == 0) check("b_cpu_done_unexpected", {31'd0, b_cpu_done}, 32'd0);
      else begin e = exp_b_c_q.pop_front(); if (e[32]) check("b_cpu_rdata_sb", b_cpu_rdata, e[31:0]); end
    end
    if (b_dma_done) begin
      if (exp_b_d_q.size() == 0) check("b_dma_done_unexpected", {31'd0, b_dma_done}, 32'd0);
      else begin e = exp_b_d_q.pop_front(); if (e[32]) check("b_dma_rdata_sb", b_dma_rdata, e[31:0]); end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    logic [31:0] ord;
    int c_cnt;

    a_rst_n = 0; b_rst_n = 0;
    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0; a_cpu_be = 0;
    a_dma_req = 0; a_dma_we = 0; a_dma_addr = 0; a_dma_wdata = 0; a_dma_be = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0; b_cpu_be = 0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0; b_dma_be = 0;
    tick(2);
    check("rst_a_mem_req",   {31'd0, a_mem_req}, 32'd0);
    check("rst_a_cpu_done",  {31'd0, a_cpu_done}, 32'd0);
    check("rst_a_dma_done",  {31'd0, a_dma_done}, 32'd0);
    check("rst_a_mem_addr",  a_mem_addr, 32'd0);
    check("rst_a_state",     {30'd0, a_dbg_state}, 32'd0);
    check("rst_b_cpu_stall", {31'd0, b_cpu_stall}, 32'd0);
    a_rst_n = 1; b_rst_n = 1;
    tick(1);

    // T1: CPU read, READ_LAT=1
    drive(0, 0, 0, 32'h100, 32'h0, 4'hF); #1;
    check("t1_stall_c0", {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t1_mem_req_c1",  {31'd0, a_mem_req}, 32'd1);
    check("t1_mem_addr_c1", a_mem_addr, 32'h100);
    check("t1_mem_we_c1",   {31'd0, a_mem_we}, 32'd0);
    check("t1_stall_c1",    {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t1_mem_req_c2",  {31'd0, a_mem_req}, 32'd0);
    check("t1_done_c2",     {31'd0, a_cpu_done}, 32'd0);
    check("t1_stall_c2",    {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t1_done_c3",     {31'd0, a_cpu_done}, 32'd1);
    check("t1_rdata_c3",    a_cpu_rdata, 32'hDEADBEEF);
    check("t1_stall_c3",    {31'd0, a_cpu_stall}, 32'd0);
    a_cpu_req = 0;
    tick();
    check("t1_done_c4",     {31'd0, a_cpu_done}, 32'd0);
    check("t1_idle_c4",     {30'd0, a_dbg_state}, 32'd0);

    // T2: simultaneous requests right after reset, round-robin
    reset_a();
    drive(0, 0, 0, 32'h200, 32'h0, 4'hF);
    drive(0, 1, 0, 32'h300, 32'h0, 4'hF); #1;
    check("t2_stall_c0", {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t2_mem_addr_c1", a_mem_addr, 32'h200);
    check("t2_stall_c1",    {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t2_stall_c2",    {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t2_cpu_done_c3", {31'd0, a_cpu_done}, 32'd1);
    check("t2_dma_done_c3", {31'd0, a_dma_done}, 32'd0);
    check("t2_stall_c3",    {31'd0, a_cpu_stall}, 32'd0);
    a_cpu_req = 0;
    tick();
    check("t2_mem_req_c4",  {31'd0, a_mem_req}, 32'd0);
    tick();
    check("t2_mem_req_c5",  {31'd0, a_mem_req}, 32'd1);
    check("t2_mem_addr_c5", a_mem_addr, 32'h300);
    tick();
    check("t2_dma_done_c6", {31'd0, a_dma_done}, 32'd0);
    tick();
    check("t2_dma_done_c7", {31'd0, a_dma_done}, 32'd1);
    check("t2_dma_rdata_c7", a_dma_rdata, 32'h0300FCFF);
    check("t2_cpu_rdata_hold", a_cpu_rdata, 32'h0200FDFF);
    a_dma_req = 0;
    tick();

    // T3a: continuous round-robin, 6 accesses
    drive(0, 0, 0, 32'h210, 32'h0, 4'hF);
    drive(0, 1, 0, 32'h310, 32'h0, 4'hF);
    for (int k = 0; k < 2; k++) begin
      sb_push(0, 0, 0, 32'h210);
      sb_push(0, 1, 0, 32'h310);
    end
    n = 0; ord = 0;
    for (int i = 0; i < 60 && n < 6; i++) begin
      tick();
      if (a_cpu_done) begin ord = {ord[30:0], 1'b0}; n++; end
      if (a_dma_done) begin ord = {ord[30:0], 1'b1}; n++; end
      if (n == 6) begin a_cpu_req = 0; a_dma_req = 0; end
    end
    a_cpu_req = 0; a_dma_req = 0;
    check("t3a_count", n, 32'd6);
    check("t3a_order_CDCDCD", ord, 32'h15);
    tick(2);
    check("t3a_idle_after", {30'd0, a_dbg_state}, 32'd0);

    // T3b: CPU priority on instance b
    drive(1, 0, 0, 32'h220, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h320, 32'h0, 4'hF);
    sb_push(1, 0, 0, 32'h220);
    sb_push(1, 0, 0, 32'h220);
    n = 0; ord = 0; c_cnt = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      tick();
      if (b_cpu_done) begin ord = {ord[30:0], 1'b0}; n++; c_cnt++; end
      if (b_dma_done) begin ord = {ord[30:0], 1'b1}; n++; b_dma_req = 0; end
      if (c_cnt == 3) b_cpu_req = 0;
    end
    b_cpu_req = 0; b_dma_req = 0;
    check("t3b_count", n, 32'd4);
    check("t3b_order_CCCD", ord, 32'h1);
    tick();

    // T4: DMA write on instance b, READ_LAT=3
    drive(1, 1, 1, 32'h40, 32'h0000ABCD, 4'b0011); #1;
    tick();
    check("t4_mem_req_c1",   {31'd0, b_mem_req}, 32'd1);
    check("t4_mem_we_c1",    {31'd0, b_mem_we}, 32'd1);
    check("t4_mem_be_c1",    {28'd0, b_mem_be}, 32'h3);
    check("t4_mem_wdata_c1", b_mem_wdata, 32'h0000ABCD);
    check("t4_mem_addr_c1",  b_mem_addr, 32'h40);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("t4_mem_req_c%0d", k),  {31'd0, b_mem_req}, 32'd0);
      check($sformatf("t4_cpu_done_c%0d", k), {31'd0, b_cpu_done}, 32'd0);
      check($sformatf("t4_dma_done_c%0d", k), {31'd0, b_dma_done}, (k == 5) ? 32'd1 : 32'd0);
    end
    check("t4_dma_rdata_hold", b_dma_rdata, 32'h0320FCDF);
    check("t4_mem_we_hold",    {31'd0, b_mem_we}, 32'd1);
    b_dma_req = 0;
    tick();
    check("t4_idle_after", {30'd0, b_dbg_state}, 32'd0);

    // T5: CPU arrives while DMA is waiting (instance a)
    drive(0, 1, 0, 32'h500, 32'h0, 4'hF);
    tick(2);
    drive(0, 0, 0, 32'h600, 32'h0, 4'hF); #1;
    check("t5_stall_c2", {31'd0, a_cpu_stall}, 32'd1);
    tick();
    check("t5_dma_done_c3", {31'd0, a_dma_done}, 32'd1);
    check("t5_stall_c3",    {31'd0, a_cpu_stall}, 32'd1);
    a_dma_req = 0;
    tick();
    check("t5_stall_c4",    {31'd0, a_cpu_stall}, 32'd1);
    check("t5_mem_req_c4",  {31'd0, a_mem_req}, 32'd0);
    tick();
    check("t5_mem_req_c5",  {31'd0, a_mem_req}, 32'd1);
    check("t5_mem_addr_c5", a_mem_addr, 32'h600);
    check("t5_stall_c5",    {31'd0, a_cpu_stall}, 32'd1);
    tick(2);
    check("t5_cpu_done_c7", {31'd0, a_cpu_done}, 32'd1);
    check("t5_stall_c7",    {31'd0, a_cpu_stall}, 32'd0);
    check("t5_cpu_rdata",   a_cpu_rdata, 32'h0600F9FF);
    a_cpu_req = 0;
    tick();

    // T6: reset during WAIT aborts the access
    drive(0, 1, 0, 32'h700, 32'h0, 4'hF);
    tick(2);
    a_rst_n = 0; a_dma_req = 0;
    void'(exp_a_d_q.pop_back());
    #1;
    check("t6_mem_req",   {31'd0, a_mem_req}, 32'd0);
    check("t6_mem_addr",  a_mem_addr, 32'd0);
    check("t6_mem_wdata", a_mem_wdata, 32'd0);
    check("t6_mem_be",    {28'd0, a_mem_be}, 32'd0);
    check("t6_dma_done",  {31'd0, a_dma_done}, 32'd0);
    check("t6_dma_rdata", a_dma_rdata, 32'd0);
    check("t6_cpu_rdata", a_cpu_rdata, 32'd0);
    check("t6_state",     {30'd0, a_dbg_state}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_done", {31'd0, a_dma_done}, 32'd0);
    end
    a_rst_n = 1;
    tick();
    drive(0, 0, 0, 32'h100, 32'h0, 4'hF);
    tick(2);
    check("t6_post_done_c2", {31'd0, a_cpu_done}, 32'd0);
    tick();
    check("t6_post_done_c3", {31'd0, a_cpu_done}, 32'd1);
    check("t6_post_rdata",   a_cpu_rdata, 32'hDEADBEEF);
    a_cpu_req = 0;
    tick(2);

    check("sb_a_c_empty", exp_a_c_q.size(), 32'd0);
    check("sb_a_d_empty", exp_a_d_q.size(), 32'd0);
    check("sb_b_c_empty", exp_b_c_q.size(), 32'd0);
    check("sb_b_d_empty", exp_b_d_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
